// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the two-requester memory access controller.
// Holds the FSM encoding, requester IDs and default bus widths.
package mem_ctrl_pkg;

   localparam int DEF_AW = 6;
   localparam int DEF_DW = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ_A = 1'b0;
   localparam req_id_t REQ_B = 1'b1;

   // One-hot grant (bit 0 = A, bit 1 = B) to requester ID.
   function automatic req_id_t winner_id(input logic [1:0] gnt);
      return gnt[1] ? REQ_B : REQ_A;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bus between the access controller and the 64x4 level-sensitive memory.
// The controller drives the master side; the memory drives mem_dataout.
interface mem_access_ctrl_if
   import mem_ctrl_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);

   logic          mem_en;
   logic          mem_rw;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_datain;
   logic [DW-1:0] mem_dataout;

   modport master (
      output mem_en, mem_rw, mem_addr, mem_datain,
      input  mem_dataout
   );

   modport slave (
      input  mem_en, mem_rw, mem_addr, mem_datain,
      output mem_dataout
   );

endinterface

// File: rtl/mem_access_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, registered
// last-grant pointer that advances only when upd is strobed with a request.
module rr_arb2
   import mem_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt
);

   req_id_t last;

   always_comb begin
      // NOTE: default assignment first so no path leaves gnt unassigned (no latch).
      gnt = 2'b00;
      if (req == 2'b01)
         gnt = 2'b01;
      else if (req == 2'b10)
         gnt = 2'b10;
      else if (req == 2'b11)
         gnt = (last == REQ_B) ? 2'b01 : 2'b10;
   end

   // Pointer starts at B so that A wins the first tie out of reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all clocked state.
      if (!rst_n)
         last <= REQ_B;
      else if (upd && (|req))
         last <= winner_id(gnt);
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates requesters A/B round-robin and runs each memory access as
// SETUP / ACCESS (mem_en high HOLD cycles) / RELEASE with registered outputs.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int AW   = DEF_AW,
   parameter int DW   = DEF_DW,
   parameter int HOLD = 1
)(
   input  logic          clk,
   input  logic          rst_n,

   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_done,
   output logic [DW-1:0] a_rdata,

   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_done,
   output logic [DW-1:0] b_rdata,

   output logic          busy,
   mem_access_ctrl_if.master mem
);

   localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

   state_t     state;
   logic [3:0] cnt;
   req_id_t    owner;
   logic [1:0] arb_gnt;
   logic       arb_upd;

   assign arb_upd = (state == IDLE);

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({b_req, a_req}),
      .upd   (arb_upd),
      .gnt   (arb_gnt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         owner           <= REQ_A;
         a_gnt           <= 1'b0;
         b_gnt           <= 1'b0;
         a_done          <= 1'b0;
         b_done          <= 1'b0;
         a_rdata         <= '0;
         b_rdata         <= '0;
         busy            <= 1'b0;
         mem.mem_en      <= 1'b0;
         mem.mem_rw      <= 1'b1;
         mem.mem_addr    <= '0;
         mem.mem_datain  <= '0;
      end else begin
         a_gnt  <= 1'b0;
         b_gnt  <= 1'b0;
         a_done <= 1'b0;
         b_done <= 1'b0;

         unique case (state)
            IDLE: begin
               // Latch the winner's fields now so they are stable through SETUP.
               if (|arb_gnt) begin
                  owner <= winner_id(arb_gnt);
                  busy  <= 1'b1;
                  state <= SETUP;
                  if (arb_gnt[0]) begin
                     a_gnt          <= 1'b1;
                     mem.mem_rw     <= ~a_we;
                     mem.mem_addr   <= a_addr;
                     mem.mem_datain <= a_wdata;
                  end else begin
                     b_gnt          <= 1'b1;
                     mem.mem_rw     <= ~b_we;
                     mem.mem_addr   <= b_addr;
                     mem.mem_datain <= b_wdata;
                  end
               end
            end

            SETUP: begin
               cnt        <= HOLD_M1;
               mem.mem_en <= 1'b1;
               state      <= ACCESS;
            end

            ACCESS: begin
               if (cnt == 4'd0) begin
                  mem.mem_en <= 1'b0;
                  state      <= RELEASE;
                  a_done     <= (owner == REQ_A);
                  b_done     <= (owner == REQ_B);
                  // Sample on the last enabled cycle, while the memory still drives.
                  if (mem.mem_rw) begin
                     if (owner == REQ_A)
                        a_rdata <= mem.mem_dataout;
                     else
                        b_rdata <= mem.mem_dataout;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            RELEASE: begin
               mem.mem_rw <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n)
         assert (HOLD >= 1 && HOLD <= 15)
            else $error("mem_access_ctrl: HOLD=%0d outside 1..15", HOLD);
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Two-requester arbiter and sequencer for the 64x4 level-sensitive memory (ports en, rw, addr, datain, dataout; rw=1 read, rw=0 write; dataout is Z while en=0).
- Accepts requests from ports A and B and grants them round-robin.
- Runs each access as a setup / enable / release sequence so the memory only sees clean en/rw edges with stable addr and data.
- Returns read data and a completion pulse to the granted requester.

Parameters:
- AW, 6, memory address width.
- DW, 4, memory data width.
- HOLD, 1, number of cycles mem_en is held high per access; legal range 1..15; 0 is illegal and is flagged by a simulation assertion.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- a_req  in  1  requester A wants an access; A holds fields stable until a_gnt.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  AW  access address.
- a_wdata  in  DW  write data.
- a_gnt  out  1  one-cycle pulse: A's request has been accepted.
- a_done  out  1  one-cycle pulse: A's access is complete.
- a_rdata  out  DW  read result; valid when a_done is high and the access was a read.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: same as the A ports, for requester B.
- busy  out  1  high in every state except IDLE.
- mem_en  out  1  memory enable.
- mem_rw  out  1  memory direction (1 = read, 0 = write).
- mem_addr  out  AW  memory address.
- mem_datain  out  DW  memory write data.
- mem_dataout  in  DW  memory read data.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, mem_en=0, mem_rw=1, mem_addr=0, mem_datain=0.
  - gnt, done, busy all 0; a_rdata=b_rdata=0.
  - last-grant pointer = B, so A wins the first tie.
- Reset mid-operation:
  - Abandons the transaction immediately; no done pulse is issued.
  - A write whose mem_en was already high may have landed in memory. This is accepted behaviour.
- FSM states: IDLE, SETUP, ACCESS, RELEASE.
- IDLE:
  - If any req is high, arbitrate and latch the winner's we/addr/wdata into mem_rw (= ~we), mem_addr and mem_datain.
  - Pulse the winner's gnt on the next cycle; go to SETUP.
  - mem_en stays 0.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not granted last wins; the pointer updates on every grant.
- SETUP:
  - One cycle; mem_en=0; address/data/rw are already stable.
  - Load the hold counter with HOLD-1; go to ACCESS.
- ACCESS:
  - mem_en=1 for exactly HOLD cycles; counter decrements each cycle.
  - On the last ACCESS cycle, a read samples mem_dataout into the owner's rdata register.
  - Go to RELEASE.
- RELEASE:
  - mem_en=0; mem_addr, mem_rw and mem_datain stay unchanged this cycle.
  - Owner's done pulses; go to IDLE.
  - In IDLE, mem_rw returns to 1; addr/datain keep their last values.
- rdata of the non-owner is never modified. Write accesses do not alter rdata.
- Latency, with req sampled at edge 0:
  - gnt high in cycle 1 (SETUP).
  - mem_en high in cycles 2..1+HOLD.
  - done in cycle 2+HOLD.
  - Earliest next grant in cycle 4+HOLD, i.e. throughput of one access per HOLD+3 cycles.
- Requests arriving during busy are ignored until IDLE; no queueing. A requester that keeps req high after gnt is treated as a new request.
- Address range 0..63 has no wrap or bounds logic; the full range is valid.

Decomposition:
- Shared package/header mem_ctrl_pkg holds:
  - state encoding: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RELEASE=2'd3;
  - requester IDs REQ_A=1'b0, REQ_B=1'b1;
  - default AW/DW constants.
- One sub-module, rr_arb2: two-input round-robin arbiter with registered last-grant pointer, inputs req[1:0] and an update strobe, output a one-hot grant. Pure arbitration only; sequencing stays in mem_access_ctrl.

Test Plan:
- Reset, then idle 5 cycles -> mem_en=0, mem_rw=1, busy=0, all gnt/done=0, rdata=0.
- A writes 4'hA to addr 6'd5, then A reads addr 5 (HOLD=1) -> a_gnt at cycle 1, mem_en high only in cycle 2, a_done at cycle 3; the read returns a_rdata=4'hA with a_done; b_rdata stays 0.
- Both requesters hold req continuously: A read addr 1, B read addr 2 -> grants alternate A,B,A,B, each 4 cycles apart; mem_addr alternates 1,2.
- HOLD=3: B writes 4'h7 to addr 63, then reads it back -> mem_en high 3 consecutive cycles per access; b_done 2+HOLD=5 cycles after req; b_rdata=4'h7.
- rst_n asserted during ACCESS of an A read -> next cycle state IDLE, mem_en=0, no a_done pulse, a_rdata=0, next simultaneous request granted to A.
- B requests while A's transaction is in ACCESS -> no b_gnt until the cycle after IDLE resumes; mem_en never rises without a preceding SETUP cycle.
